// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar read path: the responder FSM states,
// the master count and the slave command encoding.
package xbar_pkg;

    localparam int   NUM_MASTERS = 2;
    localparam logic CMD_READ    = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        RESP
    } state_t;

    // Turns a granted master index into its m_resp strobe pattern.
    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/slave_rd_responder_arb.sv
// Two-way round-robin grant: a lone requester always wins; under contention
// the master that did not win the previous contested arbitration wins.
module rr_arbiter2
    import xbar_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] pending,
    input  logic                   last,
    output logic [NUM_MASTERS-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (pending)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/slave_rd_responder.sv
// Collects one-cycle read strobes from two masters, forwards them one at a
// time to a single slave, and returns the data (or a timeout) to the requester.
module slave_rd_responder
    import xbar_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NUM_MASTERS-1:0] m_wren,
    input  logic [AWIDTH-1:0]      m_addr0,
    input  logic [AWIDTH-1:0]      m_addr1,
    output logic                   s_req,
    output logic [AWIDTH-1:0]      s_addr,
    output logic                   s_cmd,
    input  logic                   s_ack,
    input  logic                   s_resp,
    input  logic [DWIDTH-1:0]      s_rdata,
    output logic [NUM_MASTERS-1:0] m_resp,
    output logic [DWIDTH-1:0]      m_rdata,
    output logic                   m_err,
    output logic                   ovf_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t                   state;
    logic [15:0]              cnt;
    logic                     last;
    logic                     gnt_idx;

    logic [NUM_MASTERS-1:0]   pending;
    logic [AWIDTH-1:0]        slot_addr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   grant;
    logic                     grant_idx;
    logic [NUM_MASTERS-1:0]   clear;
    logic [NUM_MASTERS-1:0]   accept;

    assign s_cmd = CMD_READ;

    rr_arbiter2 u_arb (
        .pending (pending),
        .last    (last),
        .grant   (grant)
    );

    assign grant_idx = grant[1];
    assign clear     = (state == IDLE) ? grant : '0;
    // A slot freed by this edge's grant can take a new strobe at the same edge.
    assign accept    = m_wren & (~pending | clear);

    // NOTE: all state uses <= so every register samples pre-edge values,
    // and areset is checked inside the clocked block (synchronous reset).
    always_ff @(posedge aclk) begin
        if (areset) begin
            pending <= '0;
            ovf_err <= 1'b0;
        end else begin
            pending <= (pending & ~clear) | accept;
            if (|(m_wren & ~accept)) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // NOTE: slot addresses carry no reset; they are only read while their
    // pending flag is set, and that flag is reset.
    always_ff @(posedge aclk) begin
        if (accept[0]) slot_addr[0] <= m_addr0;
        if (accept[1]) slot_addr[1] <= m_addr1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            gnt_idx <= 1'b0;
            s_req   <= 1'b0;
            s_addr  <= '0;
            m_resp  <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        gnt_idx <= grant_idx;
                        // Only contested arbitrations move the round-robin pointer.
                        if (&pending) begin
                            last <= grant_idx;
                        end
                        s_req   <= 1'b1;
                        s_addr  <= {1'b0, slot_addr[grant_idx][AWIDTH-2:0]};
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end

                REQ: begin
                    if (cnt == CNT_LAST) begin
                        s_req   <= 1'b0;
                        s_addr  <= '0;
                        m_resp  <= idx_to_onehot(gnt_idx);
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (s_ack) begin
                            s_req  <= 1'b0;
                            s_addr <= '0;
                            state  <= WAIT_RESP;
                        end
                    end
                end

                WAIT_RESP: begin
                    // Data arriving on the final counted cycle still wins.
                    if (s_resp) begin
                        m_resp  <= idx_to_onehot(gnt_idx);
                        m_rdata <= s_rdata;
                        m_err   <= 1'b0;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        m_resp  <= idx_to_onehot(gnt_idx);
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESP: begin
                    m_resp  <= '0;
                    m_rdata <= '0;
                    m_err   <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_rd_responder.sv
// Scoreboard bench for slave_rd_responder: expected slave addresses and
// master responses are queued as stimulus is issued and popped on output.
module tb_slave_rd_responder;

    localparam int TO = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  m_wren;
    logic [31:0] m_addr0, m_addr1;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_cmd;
    logic        s_ack, s_resp;
    logic [31:0] s_rdata;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        ovf_err;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int sreq_rises = 0;
    logic sreq_prev = 1'b0;

    slave_rd_responder #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .m_wren  (m_wren),
        .m_addr0 (m_addr0),
        .m_addr1 (m_addr1),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_cmd   (s_cmd),
        .s_ack   (s_ack),
        .s_resp  (s_resp),
        .s_rdata (s_rdata),
        .m_resp  (m_resp),
        .m_rdata (m_rdata),
        .m_err   (m_err),
        .ovf_err (ovf_err)
    );

    always #5 aclk = ~aclk;

    // Background observers: s_req rising-edge count, and m_rdata quiet when no response.
    always @(negedge aclk) begin
        if (s_req && !sreq_prev) sreq_rises++;
        sreq_prev = s_req;
        if (m_resp == 2'b00) begin
            checks++;
            if (m_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rdata_idle: m_rdata=%h expected 00000000 with m_resp=0 at %0t", m_rdata, $time);
            end
        end
    end

    // ---------------- stimulus / observation helpers (no comparisons) -------
    task automatic request(input logic [1:0] wren, input logic [31:0] a0, input logic [31:0] a1);
        m_wren  = wren;
        m_addr0 = a0;
        m_addr1 = a1;
        @(posedge aclk); #1;
        m_wren  = 2'b00;
    endtask

    task automatic pulse_ack();
        s_ack = 1'b1;
        @(posedge aclk); #1;
        s_ack = 1'b0;
    endtask

    task automatic pulse_resp(input logic [31:0] data);
        s_resp  = 1'b1;
        s_rdata = data;
        @(posedge aclk); #1;
        s_resp  = 1'b0;
        s_rdata = '0;
    endtask

    task automatic wait_sreq(output logic [31:0] addr, output bit ok);
        ok = 0;
        addr = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            if (s_req) begin
                addr = s_addr;
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_mresp(output logic [1:0] r, output logic [31:0] d,
                              output logic e, output int n);
        r = '0; d = '0; e = 1'b0; n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            n++;
            if (m_resp != 2'b00) begin
                r = m_resp; d = m_rdata; e = m_err;
                return;
            end
        end
    endtask

    task automatic serve(input logic [31:0] data, output logic [31:0] addr, output bit ok);
        wait_sreq(addr, ok);
        if (ok) begin
            pulse_ack();
            pulse_resp(data);
        end
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.resp = 2'b11; e.data = 32'hDEAD_BEEF; e.err = 1'bx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    function automatic logic [31:0] pop_addr();
        if (addr_q.size() > 0) return addr_q.pop_front();
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        do_reset();
        @(negedge aclk);
        checks++;
        if ({s_req, s_addr, m_resp, m_rdata, m_err, ovf_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: s_req=%b s_addr=%h m_resp=%b m_rdata=%h m_err=%b ovf=%b expected all 0",
                     s_req, s_addr, m_resp, m_rdata, m_err, ovf_err);
        end
        checks++;
        if (s_cmd !== 1'b1) begin
            errors++;
            $display("FAIL s_cmd: got %b expected 1", s_cmd);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        logic [31:0] a;
        @(posedge aclk); #1;
        addr_q.push_back(32'h0000_0010);
        request(2'b01, 32'h0000_0010, 32'h0);
        @(negedge aclk);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL single_sreq_k1: s_req=%b expected 0", s_req);
        end
        @(negedge aclk);
        a = pop_addr();
        checks++;
        if (s_req !== 1'b1 || s_addr !== a) begin
            errors++;
            $display("FAIL single_sreq_k2: s_req=%b s_addr=%h expected 1 / %h", s_req, s_addr, a);
        end
        pulse_ack();
        @(negedge aclk);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL single_sreq_fall: s_req=%b expected 0 after ack", s_req);
        end
        exp_q.push_back('{resp: 2'b01, data: 32'hA5A5_0001, err: 1'b0});
        pulse_resp(32'hA5A5_0001);
        @(negedge aclk);
        e = pop_exp();
        checks++;
        if (m_resp !== e.resp || m_rdata !== e.data || m_err !== e.err) begin
            errors++;
            $display("FAIL single_resp: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                     m_resp, m_rdata, m_err, e.resp, e.data, e.err);
        end
        @(negedge aclk);
        checks++;
        if (m_resp !== 2'b00 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL single_resp_width: m_resp=%b m_err=%b expected 00 0", m_resp, m_err);
        end
        idle(2);
    endtask

    task automatic test_contention();
        logic [31:0] a, ea;
        logic [1:0]  r;
        logic [31:0] d;
        logic        er;
        int          n;
        bit          ok;
        exp_t        e;
        // First contested pair: master 0 wins; MSB of master 1's address is dropped.
        addr_q.push_back(32'h0000_0004);
        addr_q.push_back(32'h0000_0008);
        exp_q.push_back('{resp: 2'b01, data: 32'h1111_0000, err: 1'b0});
        exp_q.push_back('{resp: 2'b10, data: 32'h2222_0000, err: 1'b0});
        request(2'b11, 32'h0000_0004, 32'h8000_0008);
        for (int k = 0; k < 2; k++) begin
            serve(k == 0 ? 32'h1111_0000 : 32'h2222_0000, a, ok);
            ea = pop_addr();
            checks++;
            if (!ok || a !== ea) begin
                errors++;
                $display("FAIL contention_addr%0d: s_addr=%h seen=%0d expected %h", k, a, ok, ea);
            end
            wait_mresp(r, d, er, n);
            e = pop_exp();
            checks++;
            if (r !== e.resp || d !== e.data || er !== e.err) begin
                errors++;
                $display("FAIL contention_resp%0d: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                         k, r, d, er, e.resp, e.data, e.err);
            end
        end
        idle(2);
        // Second contested pair: master 1 now wins.
        addr_q.push_back(32'h0000_0030);
        addr_q.push_back(32'h0000_0020);
        exp_q.push_back('{resp: 2'b10, data: 32'h3333_0000, err: 1'b0});
        exp_q.push_back('{resp: 2'b01, data: 32'h4444_0000, err: 1'b0});
        request(2'b11, 32'h0000_0020, 32'h0000_0030);
        for (int k = 0; k < 2; k++) begin
            serve(k == 0 ? 32'h3333_0000 : 32'h4444_0000, a, ok);
            ea = pop_addr();
            checks++;
            if (!ok || a !== ea) begin
                errors++;
                $display("FAIL rr_addr%0d: s_addr=%h seen=%0d expected %h", k, a, ok, ea);
            end
            wait_mresp(r, d, er, n);
            e = pop_exp();
            checks++;
            if (r !== e.resp || d !== e.data || er !== e.err) begin
                errors++;
                $display("FAIL rr_resp%0d: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                         k, r, d, er, e.resp, e.data, e.err);
            end
        end
        idle(2);
    endtask

    task automatic test_grant_cycle_strobe();
        logic [31:0] a, ea;
        logic [1:0]  r;
        logic [31:0] d;
        logic        er;
        int          n;
        bit          ok;
        exp_t        e;
        addr_q.push_back(32'h0000_0080);
        addr_q.push_back(32'h0000_0084);
        exp_q.push_back('{resp: 2'b01, data: 32'h5555_0001, err: 1'b0});
        exp_q.push_back('{resp: 2'b01, data: 32'h5555_0002, err: 1'b0});
        request(2'b01, 32'h0000_0080, 32'h0);
        request(2'b01, 32'h0000_0084, 32'h0);   // lands on the grant edge
        for (int k = 0; k < 2; k++) begin
            serve(32'h5555_0001 + 32'(k), a, ok);
            ea = pop_addr();
            checks++;
            if (!ok || a !== ea) begin
                errors++;
                $display("FAIL grant_cycle_addr%0d: s_addr=%h seen=%0d expected %h", k, a, ok, ea);
            end
            wait_mresp(r, d, er, n);
            e = pop_exp();
            checks++;
            if (r !== e.resp || d !== e.data || er !== e.err) begin
                errors++;
                $display("FAIL grant_cycle_resp%0d: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                         k, r, d, er, e.resp, e.data, e.err);
            end
        end
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL grant_cycle_ovf: ovf_err=%b expected 0", ovf_err);
        end
        idle(2);
    endtask

    task automatic test_timeout(input bit with_ack);
        logic [31:0] a, ea;
        logic [1:0]  r;
        logic [31:0] d;
        logic        er;
        int          n;
        bit          ok;
        exp_t        e;
        addr_q.push_back(32'h0000_0100);
        exp_q.push_back('{resp: 2'b10, data: 32'h0, err: 1'b1});
        request(2'b10, 32'h0, 32'h0000_0100);
        wait_sreq(a, ok);
        ea = pop_addr();
        checks++;
        if (!ok || a !== ea) begin
            errors++;
            $display("FAIL timeout_addr ack=%0d: s_addr=%h seen=%0d expected %h", with_ack, a, ok, ea);
        end
        if (with_ack) pulse_ack();
        wait_mresp(r, d, er, n);
        e = pop_exp();
        checks++;
        if (r !== e.resp || d !== e.data || er !== e.err || n != TO) begin
            errors++;
            $display("FAIL timeout_resp ack=%0d: m_resp=%b m_rdata=%h m_err=%b cycles=%0d expected %b %h %b %0d",
                     with_ack, r, d, er, n, e.resp, e.data, e.err, TO);
        end
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sreq ack=%0d: s_req=%b expected 0", with_ack, s_req);
        end
        @(negedge aclk);
        checks++;
        if (m_resp !== 2'b00 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle ack=%0d: m_resp=%b m_err=%b expected 00 0", with_ack, m_resp, m_err);
        end
        idle(2);
    endtask

    task automatic test_coincide();
        logic [31:0] a, ea;
        bit          ok;
        exp_t        e;
        addr_q.push_back(32'h0000_0200);
        exp_q.push_back('{resp: 2'b01, data: 32'hC0C0_C0C0, err: 1'b0});
        request(2'b01, 32'h0000_0200, 32'h0);
        wait_sreq(a, ok);
        ea = pop_addr();
        checks++;
        if (!ok || a !== ea) begin
            errors++;
            $display("FAIL coincide_addr: s_addr=%h seen=%0d expected %h", a, ok, ea);
        end
        pulse_ack();
        repeat (TO - 2) @(posedge aclk);   // reach the last counted cycle
        #1;
        pulse_resp(32'hC0C0_C0C0);
        @(negedge aclk);
        e = pop_exp();
        checks++;
        if (m_resp !== e.resp || m_rdata !== e.data || m_err !== e.err) begin
            errors++;
            $display("FAIL coincide_resp: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                     m_resp, m_rdata, m_err, e.resp, e.data, e.err);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        logic [31:0] a, ea;
        logic [1:0]  r;
        logic [31:0] d;
        logic        er;
        int          n, base;
        bit          ok;
        exp_t        e;
        addr_q.push_back(32'h0000_0040);
        addr_q.push_back(32'h0000_0044);
        exp_q.push_back('{resp: 2'b01, data: 32'h0F0F_0001, err: 1'b0});
        exp_q.push_back('{resp: 2'b01, data: 32'h0F0F_0002, err: 1'b0});
        request(2'b01, 32'h0000_0040, 32'h0);
        wait_sreq(a, ok);
        ea = pop_addr();
        checks++;
        if (!ok || a !== ea) begin
            errors++;
            $display("FAIL ovf_addr0: s_addr=%h seen=%0d expected %h", a, ok, ea);
        end
        pulse_ack();
        request(2'b01, 32'h0000_0044, 32'h0);   // slot free: accepted
        @(negedge aclk);
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: ovf_err=%b expected 0", ovf_err);
        end
        @(posedge aclk); #1;
        request(2'b01, 32'h0000_0048, 32'h0);   // slot busy: dropped
        @(negedge aclk);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_second: ovf_err=%b expected 1", ovf_err);
        end
        @(posedge aclk); #1;
        pulse_resp(32'h0F0F_0001);
        wait_mresp(r, d, er, n);
        e = pop_exp();
        checks++;
        if (r !== e.resp || d !== e.data || er !== e.err) begin
            errors++;
            $display("FAIL ovf_resp0: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                     r, d, er, e.resp, e.data, e.err);
        end
        base = sreq_rises;
        serve(32'h0F0F_0002, a, ok);
        ea = pop_addr();
        checks++;
        if (!ok || a !== ea) begin
            errors++;
            $display("FAIL ovf_addr1: s_addr=%h seen=%0d expected %h", a, ok, ea);
        end
        wait_mresp(r, d, er, n);
        e = pop_exp();
        checks++;
        if (r !== e.resp || d !== e.data || er !== e.err) begin
            errors++;
            $display("FAIL ovf_resp1: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                     r, d, er, e.resp, e.data, e.err);
        end
        idle(30);
        checks++;
        if (sreq_rises - base != 1) begin
            errors++;
            $display("FAIL ovf_sreq_count: %0d slave requests expected 1", sreq_rises - base);
        end
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf_err=%b expected 1", ovf_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, ea;
        logic [1:0]  r;
        logic [31:0] d;
        logic        er;
        int          n, seen;
        bit          ok;
        exp_t        e;
        request(2'b01, 32'h0000_0060, 32'h0);
        wait_sreq(a, ok);
        pulse_ack();
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({s_req, s_addr, m_resp, m_rdata, m_err, ovf_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: s_req=%b s_addr=%h m_resp=%b m_rdata=%h m_err=%b ovf=%b expected all 0",
                     s_req, s_addr, m_resp, m_rdata, m_err, ovf_err);
        end
        pulse_resp(32'hBAD0_BAD0);   // late response, must be ignored
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (m_resp != 2'b00 || s_req) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d active cycles expected 0", seen);
        end
        @(posedge aclk); #1;
        addr_q.push_back(32'h0000_0070);
        exp_q.push_back('{resp: 2'b10, data: 32'h7777_7777, err: 1'b0});
        request(2'b10, 32'h0, 32'h0000_0070);
        serve(32'h7777_7777, a, ok);
        ea = pop_addr();
        checks++;
        if (!ok || a !== ea) begin
            errors++;
            $display("FAIL reset_mid_addr: s_addr=%h seen=%0d expected %h", a, ok, ea);
        end
        wait_mresp(r, d, er, n);
        e = pop_exp();
        checks++;
        if (r !== e.resp || d !== e.data || er !== e.err) begin
            errors++;
            $display("FAIL reset_mid_resp: m_resp=%b m_rdata=%h m_err=%b expected %b %h %b",
                     r, d, er, e.resp, e.data, e.err);
        end
        idle(2);
    endtask

    initial begin
        areset  = 1'b1;
        m_wren  = '0;
        m_addr0 = '0;
        m_addr1 = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;

        test_reset();
        test_single_read();
        test_contention();
        test_grant_cycle_strobe();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_coincide();
        test_overflow();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
